tone_sequencer: RTL and testbench

//  Plays a programmable note sequence by configuring the square-wave generator's tone period.

---
 rtl/tone_sequencer_pkg.sv | 23 ++
 rtl/tone_sequencer_table.sv | 29 ++
 rtl/tone_sequencer.sv | 158 +++++++++++++++
 tb/tb_tone_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: FSM states, button and LED bit positions.
package tone_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Button pulse bit positions
  localparam int BTN_PLAY    = 0;
  localparam int BTN_RESTART = 1;
  localparam int BTN_LOOP    = 2;

  // LED bit positions
  localparam int LED_PLAY  = 0;
  localparam int LED_PAUSE = 1;
  localparam int LED_LOOP  = 2;
  localparam int LED_DONE  = 3;

endpackage

// File: rtl/tone_sequencer_table.sv
// Note table: synchronous write, synchronous read-first, one-cycle read latency.
module tone_table #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Write port and registered read port; the read sees the pre-write contents on a collision.
  // NOTE: the storage array has no reset so it maps onto block RAM; contents are defined only after a write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/tone_sequencer.sv
// Walks the note table and drives the square-wave generator's period/enable, timing notes in sample ticks.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int NUM_NOTES = 16,
  parameter int PERIOD_W  = 24,
  parameter int DUR_W     = 16,
  parameter int ADDR_W    = $clog2(NUM_NOTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          buttons,
  input  logic                next_sample,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [DUR_W-1:0]    wr_dur,
  output logic [PERIOD_W-1:0] tone_period,
  output logic                tone_en,
  output logic                tone_load,
  output logic [ADDR_W-1:0]   note_idx,
  output logic                done,
  output logic [3:0]          leds
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NOTES - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_idx, w_idx_nxt;
  logic [DUR_W-1:0]      r_cnt, w_cnt_nxt;
  logic [PERIOD_W-1:0]   r_tone_period, w_period_nxt;
  logic                  r_tone_load, w_load_nxt;
  logic                  r_tone_en, w_tone_en_nxt;
  logic                  r_loop;
  logic [PERIOD_W+DUR_W-1:0] w_rd_data;
  logic [PERIOD_W-1:0]   w_rd_period;
  logic [DUR_W-1:0]      w_rd_dur;
  logic                  w_play, w_restart;

  assign w_play    = buttons[BTN_PLAY];
  assign w_restart = buttons[BTN_RESTART];

  // The read address follows the next index so the entry is ready during the LOAD cycle.
  tone_table #(
    .DEPTH  (NUM_NOTES),
    .ADDR_W (ADDR_W),
    .DATA_W (PERIOD_W + DUR_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({wr_period, wr_dur}),
    .rd_addr (w_idx_nxt),
    .rd_data (w_rd_data)
  );

  assign w_rd_period = w_rd_data[DUR_W +: PERIOD_W];
  assign w_rd_dur    = w_rd_data[DUR_W-1:0];

  // Next-state, index, counter and latched-note decisions.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_tone_period;
    w_load_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_restart || w_play) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (w_restart) begin
          w_idx_nxt = '0;
        end else if (w_rd_dur == '0) begin
          // End-of-sequence marker: wrap when looping, otherwise finish.
          w_idx_nxt   = '0;
          w_state_nxt = r_loop ? ST_LOAD : ST_DONE;
        end else begin
          w_state_nxt  = ST_PLAY;
          w_period_nxt = w_rd_period;
          w_cnt_nxt    = w_rd_dur;
          w_load_nxt   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_restart) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
        end else if (w_play) begin
          w_state_nxt = ST_PAUSE;
        end else if (next_sample) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == DUR_W'(1)) begin
            if (r_idx == LAST_IDX) begin
              w_idx_nxt   = '0;
              w_state_nxt = r_loop ? ST_LOAD : ST_DONE;
            end else begin
              w_idx_nxt   = r_idx + 1'b1;
              w_state_nxt = ST_LOAD;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (w_restart) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
        end else if (w_play) begin
          w_state_nxt = ST_PLAY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_tone_en_nxt = (w_state_nxt == ST_PLAY) && (w_period_nxt != '0);
  end

  // State, index, counter, loop flag and generator-facing output registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_tone_period <= '0;
      r_tone_load   <= 1'b0;
      r_tone_en     <= 1'b0;
      r_loop        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      r_tone_period <= w_period_nxt;
      r_tone_load   <= w_load_nxt;
      r_tone_en     <= w_tone_en_nxt;
      r_loop        <= r_loop ^ buttons[BTN_LOOP];
    end
  end

  // Status decode straight from registered state.
  always_comb begin
    leds            = '0;
    leds[LED_PLAY]  = (r_state == ST_PLAY);
    leds[LED_PAUSE] = (r_state == ST_PAUSE);
    leds[LED_LOOP]  = r_loop;
    leds[LED_DONE]  = (r_state == ST_DONE);
  end

  assign tone_period = r_tone_period;
  assign tone_en     = r_tone_en;
  assign tone_load   = r_tone_load;
  assign note_idx    = r_idx;
  assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: sequence playback, looping, pause/resume, restart priority,
// table rewrite during playback and asynchronous reset.
module tb_tone_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  buttons;
  logic        next_sample;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [23:0] wr_period;
  logic [15:0] wr_dur;
  logic [23:0] tone_period;
  logic        tone_en;
  logic        tone_load;
  logic [3:0]  note_idx;
  logic        done;
  logic [3:0]  leds;

  int n_checks = 0;
  int n_errors = 0;

  tone_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .buttons     (buttons),
    .next_sample (next_sample),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_period   (wr_period),
    .wr_dur      (wr_dur),
    .tone_period (tone_period),
    .tone_en     (tone_en),
    .tone_load   (tone_load),
    .note_idx    (note_idx),
    .done        (done),
    .leds        (leds)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  // Safety net: the run is fixed-length, this only fires if something stalls the scheduler.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] mask);
    buttons = mask;
    step();
    buttons = 3'b000;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      next_sample = 1'b1;
      step();
      next_sample = 1'b0;
    end
  endtask

  task automatic write_note(input logic [3:0] a, input logic [23:0] p, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_period = p; wr_dur = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (tone_period !== 24'd0) begin n_errors++; $display("FAIL reset_period: got %0d want 0", tone_period); end
    n_checks++; if (tone_en !== 1'b0) begin n_errors++; $display("FAIL reset_en: got %b want 0", tone_en); end
    n_checks++; if (tone_load !== 1'b0) begin n_errors++; $display("FAIL reset_load: got %b want 0", tone_load); end
    n_checks++; if (note_idx !== 4'd0) begin n_errors++; $display("FAIL reset_idx: got %0d want 0", note_idx); end
    n_checks++; if ({done, leds} !== 5'b0) begin n_errors++; $display("FAIL reset_status: got done=%b leds=%b want 0/0000", done, leds); end
  endtask

  // Three notes plus marker, no loop: full pass ending in DONE.
  task automatic test_play_sequence();
    write_note(4'd0, 24'd1000, 16'd4);
    write_note(4'd1, 24'd0,    16'd2);
    write_note(4'd2, 24'd500,  16'd3);
    write_note(4'd3, 24'd0,    16'd0);
    press(3'b001);
    n_checks++; if ({tone_load, tone_en} !== 2'b00) begin n_errors++; $display("FAIL seq_load_cycle: got load/en=%b%b want 00", tone_load, tone_en); end
    step();
    n_checks++; if (tone_period !== 24'd1000) begin n_errors++; $display("FAIL seq_note0_period: got %0d want 1000", tone_period); end
    n_checks++; if ({tone_load, tone_en} !== 2'b11) begin n_errors++; $display("FAIL seq_note0_load_en: got %b%b want 11", tone_load, tone_en); end
    n_checks++; if (leds !== 4'b0001) begin n_errors++; $display("FAIL seq_note0_leds: got %b want 0001", leds); end
    tick(3);
    n_checks++; if ({leds[0], note_idx} !== 5'b1_0000) begin n_errors++; $display("FAIL seq_note0_held: got play=%b idx=%0d want 1/0", leds[0], note_idx); end
    tick(1);
    step();
    n_checks++; if ({tone_period, tone_en, tone_load, note_idx} !== {24'd0, 1'b0, 1'b1, 4'd1}) begin n_errors++; $display("FAIL seq_rest: got period=%0d en=%b load=%b idx=%0d want 0/0/1/1", tone_period, tone_en, tone_load, note_idx); end
    tick(2);
    step();
    n_checks++; if ({tone_period, tone_en, note_idx} !== {24'd500, 1'b1, 4'd2}) begin n_errors++; $display("FAIL seq_note2: got period=%0d en=%b idx=%0d want 500/1/2", tone_period, tone_en, note_idx); end
    tick(2);
    n_checks++; if (leds[0] !== 1'b1) begin n_errors++; $display("FAIL seq_note2_held: got play=%b want 1", leds[0]); end
    tick(1);
    step();
    n_checks++; if ({done, leds, tone_en} !== {1'b1, 4'b1000, 1'b0}) begin n_errors++; $display("FAIL seq_done: got done=%b leds=%b en=%b want 1/1000/0", done, leds, tone_en); end
  endtask

  // Loop on: the marker wraps back to note 0 instead of finishing.
  task automatic test_loop();
    press(3'b100);
    n_checks++; if (leds !== 4'b1100) begin n_errors++; $display("FAIL loop_toggle_leds: got %b want 1100", leds); end
    press(3'b001);
    step();
    tick(4); step();
    tick(2); step();
    tick(3); step();
    n_checks++; if ({done, leds, note_idx} !== {1'b0, 4'b0100, 4'd0}) begin n_errors++; $display("FAIL loop_wrap_load: got done=%b leds=%b idx=%0d want 0/0100/0", done, leds, note_idx); end
    step();
    n_checks++; if ({tone_period, tone_load, leds} !== {24'd1000, 1'b1, 4'b0101}) begin n_errors++; $display("FAIL loop_reload: got period=%0d load=%b leds=%b want 1000/1/0101", tone_period, tone_load, leds); end
  endtask

  // Pause after 2 ticks of note 0, ignored ticks, then exactly 2 more ticks to finish the note.
  task automatic test_pause_resume();
    tick(2);
    press(3'b001);
    n_checks++; if ({leds, tone_en} !== {4'b0110, 1'b0}) begin n_errors++; $display("FAIL pause_enter: got leds=%b en=%b want 0110/0", leds, tone_en); end
    tick(10);
    n_checks++; if ({leds, note_idx} !== {4'b0110, 4'd0}) begin n_errors++; $display("FAIL pause_frozen: got leds=%b idx=%0d want 0110/0", leds, note_idx); end
    press(3'b001);
    n_checks++; if ({tone_en, tone_load, tone_period} !== {1'b1, 1'b0, 24'd1000}) begin n_errors++; $display("FAIL pause_resume: got en=%b load=%b period=%0d want 1/0/1000", tone_en, tone_load, tone_period); end
    tick(1);
    n_checks++; if ({leds[0], note_idx} !== 5'b1_0000) begin n_errors++; $display("FAIL pause_remaining1: got play=%b idx=%0d want 1/0", leds[0], note_idx); end
    tick(1);
    n_checks++; if ({leds, note_idx} !== {4'b0100, 4'd1}) begin n_errors++; $display("FAIL pause_remaining2: got leds=%b idx=%0d want 0100/1", leds, note_idx); end
  endtask

  // Restart and play together (with a sample tick) while note 2 plays: restart wins.
  task automatic test_restart_priority();
    step();
    tick(2); step();
    n_checks++; if ({tone_period, note_idx} !== {24'd500, 4'd2}) begin n_errors++; $display("FAIL restart_setup: got period=%0d idx=%0d want 500/2", tone_period, note_idx); end
    buttons = 3'b011; next_sample = 1'b1;
    step();
    buttons = 3'b000; next_sample = 1'b0;
    n_checks++; if ({tone_en, leds, note_idx} !== {1'b0, 4'b0100, 4'd0}) begin n_errors++; $display("FAIL restart_load: got en=%b leds=%b idx=%0d want 0/0100/0", tone_en, leds, note_idx); end
    step();
    n_checks++; if ({tone_period, tone_load, tone_en} !== {24'd1000, 1'b1, 1'b1}) begin n_errors++; $display("FAIL restart_replay: got period=%0d load=%b en=%b want 1000/1/1", tone_period, tone_load, tone_en); end
  endtask

  // Rewrite the playing entry: current note unchanged, next pass picks up {777,5}.
  task automatic test_write_during_play();
    write_note(4'd0, 24'd777, 16'd5);
    n_checks++; if ({tone_period, tone_load, tone_en} !== {24'd1000, 1'b0, 1'b1}) begin n_errors++; $display("FAIL wr_current_kept: got period=%0d load=%b en=%b want 1000/0/1", tone_period, tone_load, tone_en); end
    tick(4); step();
    tick(2); step();
    tick(3); step();
    step();
    n_checks++; if ({tone_period, tone_load, note_idx} !== {24'd777, 1'b1, 4'd0}) begin n_errors++; $display("FAIL wr_new_loaded: got period=%0d load=%b idx=%0d want 777/1/0", tone_period, tone_load, note_idx); end
    tick(4);
    n_checks++; if (leds[0] !== 1'b1) begin n_errors++; $display("FAIL wr_new_dur4: got play=%b want 1", leds[0]); end
    tick(1);
    n_checks++; if ({leds, note_idx} !== {4'b0100, 4'd1}) begin n_errors++; $display("FAIL wr_new_dur5: got leds=%b idx=%0d want 0100/1", leds, note_idx); end
    step();
    tick(2); step();
  endtask

  // Asynchronous reset mid-PLAY clears outputs before any clock edge; the table survives.
  task automatic test_async_reset();
    n_checks++; if ({tone_period, tone_en, leds} !== {24'd500, 1'b1, 4'b0101}) begin n_errors++; $display("FAIL arst_setup: got period=%0d en=%b leds=%b want 500/1/0101", tone_period, tone_en, leds); end
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if ({tone_period, tone_en, tone_load, note_idx, done, leds} !== 35'd0) begin n_errors++; $display("FAIL arst_outputs: got period=%0d en=%b load=%b idx=%0d done=%b leds=%b want all 0", tone_period, tone_en, tone_load, note_idx, done, leds); end
    #1;
    rst = 1'b1;
    step();
    n_checks++; if ({leds, tone_en} !== 5'b0) begin n_errors++; $display("FAIL arst_idle: got leds=%b en=%b want 0000/0", leds, tone_en); end
    press(3'b001);
    step();
    n_checks++; if ({tone_period, tone_load} !== {24'd777, 1'b1}) begin n_errors++; $display("FAIL arst_table_kept: got period=%0d load=%b want 777/1", tone_period, tone_load); end
  endtask

  initial begin
    rst = 1'b0; buttons = 3'b000; next_sample = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
    #10;
    test_reset();
    rst = 1'b1;
    step();
    test_play_sequence();
    test_loop();
    test_pause_resume();
    test_restart_priority();
    test_write_during_play();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
